// File: rtl/pcileech_ft601_rx_buf.sv
// FT601 receive buffer: pairs incoming 32-bit dwords into 64-bit words
// ({second, first}), drops filler and stale half-pairs, and queues the
// pairs in a first-word-fall-through FIFO with overflow/drop accounting.
module pcileech_ft601_rx_buf #(
  parameter int DEPTH        = 16,
  parameter int PAIR_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              din,
  input  logic                     din_valid,
  output logic [63:0]              dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   rx_level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  input  logic                     clr_status,
  input  logic                     led_state_invert,
  output logic                     led_state_rxdata
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [7:0]      TMO_LAST = 8'(PAIR_TIMEOUT - 1);
  localparam logic [31:0]     FILLER   = 32'h6666_5555;

  typedef enum logic {IDLE, HALF} state_t;

  // Saturating 8-bit add used for the drop counter.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  state_t          state;
  logic [31:0]     lo_reg;
  logic [7:0]      tmo_cnt;
  logic            rst_sync_p0, rst_sync_p1;
  logic [63:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  logic            acc_vld;
  logic            push_req, push_ok, push_rej, pop, tmo_drop;
  logic [63:0]     push_word;
  logic [7:0]      drop_inc, drop_base;

  // Reset release is resynchronised so input is ignored for two edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_p0 <= 1'b0;
      rst_sync_p1 <= 1'b0;
    end else begin
      rst_sync_p0 <= 1'b1;
      rst_sync_p1 <= rst_sync_p0;
    end
  end

  assign acc_vld   = din_valid & rst_sync_p1;
  assign push_req  = (state == HALF) & acc_vld;
  assign push_word = {din, lo_reg};
  assign tmo_drop  = (state == HALF) & ~acc_vld & (tmo_cnt == TMO_LAST);
  assign dout_valid = (count != '0);
  assign pop       = dout_valid & dout_ready;
  assign push_ok   = push_req & ((count != FULL_LVL) | pop);
  assign push_rej  = push_req & ~push_ok;
  assign drop_inc  = {6'd0, push_rej, tmo_drop};
  assign drop_base = clr_status ? 8'd0 : drop_cnt;
  assign dout      = dout_valid ? mem[rd_ptr] : 64'd0;
  assign rx_level  = count;

  // Pairing FSM: hold the low dword, then complete or time it out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lo_reg  <= 32'd0;
      tmo_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_vld && din != FILLER) begin
            lo_reg  <= din;
            tmo_cnt <= 8'd0;
            state   <= HALF;
          end
        end
        HALF: begin
          if (acc_vld) begin
            state <= IDLE;
          end else if (tmo_drop) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky status; an event in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      overflow <= push_rej | (overflow & ~clr_status);
      drop_cnt <= sat_add8(drop_base, drop_inc);
    end
  end

  // Registered activity LED with selectable polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_state_rxdata <= 1'b0;
    else        led_state_rxdata <= led_state_invert ^ dout_valid;
  end

endmodule

// File: tb/tb_pcileech_ft601_rx_buf.sv
// Bench for pcileech_ft601_rx_buf: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_pcileech_ft601_rx_buf;

  localparam int DEPTH = 8;
  localparam int PT    = 5;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] FILLER = 32'h6666_5555;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   din = '0;
  logic          din_valid = 1'b0;
  logic [63:0]   dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic [LW-1:0] rx_level;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic          clr_status = 1'b0;
  logic          led_state_invert = 1'b0;
  logic          led_state_rxdata;

  pcileech_ft601_rx_buf #(.DEPTH(DEPTH), .PAIR_TIMEOUT(PT)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .rx_level(rx_level), .overflow(overflow), .drop_cnt(drop_cnt),
    .clr_status(clr_status), .led_state_invert(led_state_invert),
    .led_state_rxdata(led_state_rxdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state (post-edge view).
  int          m_edges;
  bit          m_half;
  logic [31:0] m_lo;
  int          m_idle;
  logic [63:0] m_q[$];
  bit          m_ovf;
  int          m_drop;
  bit          m_led;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_edges = 0; m_half = 0; m_lo = '0; m_idle = 0;
    m_q.delete(); m_ovf = 0; m_drop = 0; m_led = 0;
  endtask

  task automatic check_all();
    logic [63:0] exp_dout;
    exp_dout = (m_q.size() > 0) ? m_q[0] : 64'd0;
    check("dout", dout, exp_dout);
    check("dout_valid", 64'(dout_valid), 64'(m_q.size() > 0));
    check("rx_level", 64'(rx_level), 64'(m_q.size()));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check("led", 64'(led_state_rxdata), 64'(m_led));
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit v, input logic [31:0] d, input bit rdy,
                       input bit clr, input bit inv);
    bit   acc, pop, push, ovf_ev;
    int   inc, base, sz;
    logic [63:0] pw;
    din = d; din_valid = v; dout_ready = rdy; clr_status = clr;
    led_state_invert = inv;
    acc = v && (m_edges >= 2);
    sz = m_q.size();
    pop = (sz > 0) && rdy;
    push = 0; ovf_ev = 0; inc = 0; pw = '0;
    m_led = inv ^ (sz > 0);
    if (acc) begin
      if (!m_half) begin
        if (d != FILLER) begin m_lo = d; m_half = 1; m_idle = 0; end
      end else begin
        push = 1; pw = {d, m_lo}; m_half = 0;
      end
    end else if (m_half) begin
      m_idle++;
      if (m_idle == PT) begin m_half = 0; inc = 1; end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) m_q.push_back(pw);
      else begin ovf_ev = 1; inc += 2; end
    end
    base = clr ? 0 : m_drop;
    m_drop = (base + inc > 255) ? 255 : base + inc;
    m_ovf = ovf_ev | (clr ? 1'b0 : m_ovf);
    if (m_edges < 2) m_edges++;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    din_valid = 0; dout_ready = 0; clr_status = 0;
    rst_n = 0;
    #2;
    check("rst_dout", dout, 64'd0);
    check("rst_dout_valid", 64'(dout_valid), 64'd0);
    check("rst_rx_level", 64'(rx_level), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_led", 64'(led_state_rxdata), 64'd0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 32'd0, rdy, 0, 0);
  endtask

  task automatic send_pair(input logic [31:0] lo, input logic [31:0] hi, input bit rdy);
    cycle(1, lo, rdy, 0, 0);
    cycle(1, hi, rdy, 0, 0);
  endtask

  initial begin
    model_clear();
    @(posedge clk); #1;
    do_reset();
    idle(2, 0);

    // Filler in IDLE is dropped; real dwords pair up.
    cycle(1, FILLER, 0, 0, 0);
    cycle(1, FILLER, 0, 0, 0);
    send_pair(32'h1111_1111, 32'h2222_2222, 0);
    check("t032_dout", dout, 64'h22222222_11111111);
    check("t032_level", 64'(rx_level), 64'd1);
    check("t032_drop", 64'(drop_cnt), 64'd0);
    idle(2, 1);

    // Filler as the high half is data.
    send_pair(32'hAAAA_AAAA, FILLER, 0);
    check("t033_dout", dout, 64'h66665555_AAAAAAAA);
    idle(1, 1);

    // Lone dword times out after PT idle cycles.
    cycle(1, 32'h1234_5678, 0, 0, 0);
    idle(PT, 0);
    send_pair(32'd1, 32'd2, 0);
    check("t034_drop", 64'(drop_cnt), 64'd1);
    check("t034_dout", dout, 64'h00000002_00000001);
    check("t034_level", 64'(rx_level), 64'd1);
    idle(1, 1);

    // Overflow: DEPTH+1 pairs without draining.
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i <= DEPTH; i++) send_pair(32'h100 + i, 32'h200 + i, 0);
    check("t035_level", 64'(rx_level), 64'(DEPTH));
    check("t035_ovf", 64'(overflow), 64'd1);
    check("t035_drop", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < DEPTH; i++) begin
      check("t035_order", dout, {32'h200 + i, 32'h100 + i});
      cycle(0, 0, 1, 0, 0);
    end
    check("t035_empty", 64'(rx_level), 64'd0);

    // Full FIFO, push and pop in the same cycle.
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) send_pair(32'h300 + i, 32'h400 + i, 0);
    cycle(1, 32'hBEEF_0001, 0, 0, 0);
    cycle(1, 32'hBEEF_0002, 1, 0, 0);
    check("t036_level", 64'(rx_level), 64'(DEPTH));
    check("t036_ovf", 64'(overflow), 64'd0);

    // Saturation of drop_cnt while full.
    for (int i = 0; i < 130; i++) send_pair(32'h500 + i, 32'h600 + i, 0);
    check("sat_drop", 64'(drop_cnt), 64'd255);
    // Clear collides with a rejected push: the event wins.
    cycle(1, 32'h7, 0, 0, 0);
    cycle(1, 32'h8, 0, 1, 0);
    check("clr_evt_drop", 64'(drop_cnt), 64'd2);
    check("clr_evt_ovf", 64'(overflow), 64'd1);
    cycle(0, 0, 0, 1, 0);
    check("clr_drop", 64'(drop_cnt), 64'd0);
    check("clr_ovf", 64'(overflow), 64'd0);
    idle(DEPTH, 1);

    // Reset mid-pair with entries queued.
    for (int i = 0; i < 3; i++) send_pair(32'h900 + i, 32'hA00 + i, 0);
    cycle(1, 32'hDEAD_0000, 0, 0, 0);
    #2;
    do_reset();
    idle(2, 0);
    send_pair(32'd5, 32'd6, 0);
    check("t037_dout", dout, 64'h00000006_00000005);
    check("t037_level", 64'(rx_level), 64'd1);
    idle(PT + 2, 0);
    check("t037_only", 64'(rx_level), 64'd1);
    idle(1, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit v, rdy, clr, inv;
      logic [31:0] d;
      v   = ($urandom_range(0, 2) != 0);
      d   = ($urandom_range(0, 3) == 0) ? FILLER : $urandom;
      rdy = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 63) == 0);
      inv = $urandom_range(0, 1);
      if (i == 2200) begin
        #2;
        do_reset();
      end
      cycle(v, d, rdy, clr, inv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
